// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared MFCC DCT sizes, Q1.15 scaling and FSM state type
package mfcc_pkg;

  localparam int DCT_NUM_FILTERS = 40;
  localparam int DCT_NUM_CEPS    = 12;
  localparam int MEL_WIDTH       = 8;
  localparam int CEPS_WIDTH      = 16;
  localparam int COS_WIDTH       = 16;
  localparam int Q_FRAC          = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT,
    ST_DONE
  } dct_state_e;

endpackage

// File: rtl/dct_cos_rom.sv
// rtl/dct_cos_rom.sv - combinational Q1.15 DCT-II cosine table C[k][n] for k = 1..NUM_CEPS
module dct_cos_rom
  import mfcc_pkg::*;
#(
  parameter int NUM_CEPS    = DCT_NUM_CEPS,
  parameter int NUM_FILTERS = DCT_NUM_FILTERS
) (
  input  logic [$clog2(NUM_CEPS)-1:0]    k_idx,
  input  logic [$clog2(NUM_FILTERS)-1:0] n_idx,
  output logic signed [COS_WIDTH-1:0]    coef
);

  localparam int ENTRIES = NUM_CEPS * NUM_FILTERS;

  typedef logic [ENTRIES*COS_WIDTH-1:0] table_t;

  // Row k_idx holds coefficient k = k_idx+1; c0 is never needed.
  function automatic table_t build_table();
    table_t t;
    real    ang;
    real    v;
    int     q;
    t = '0;
    for (int k = 1; k <= NUM_CEPS; k++) begin
      for (int n = 0; n < NUM_FILTERS; n++) begin
        ang = 3.14159265358979323846 * real'(k * (2 * n + 1)) / real'(2 * NUM_FILTERS);
        v   = 32768.0 * $cos(ang);
        q   = int'(v);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        t[((k - 1) * NUM_FILTERS + n) * COS_WIDTH +: COS_WIDTH] = COS_WIDTH'(q);
      end
    end
    return t;
  endfunction

  localparam table_t COS_TABLE = build_table();

  int addr;

  always_comb begin
    addr = int'(k_idx) * NUM_FILTERS + int'(n_idx);
    coef = COS_TABLE[addr * COS_WIDTH +: COS_WIDTH];
  end

endmodule

// File: rtl/mfcc_dct.sv
// rtl/mfcc_dct.sv - frame buffer, serial MAC DCT-II and saturating coefficient output
module mfcc_dct
  import mfcc_pkg::*;
#(
  parameter int NUM_CEPS    = DCT_NUM_CEPS,
  parameter int NUM_FILTERS = DCT_NUM_FILTERS,
  parameter int INPUT_WIDTH = MEL_WIDTH,
  parameter int CEPS_WIDTH  = mfcc_pkg::CEPS_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [$clog2(NUM_FILTERS)-1:0]  frame_ptr_i,
  input  logic [INPUT_WIDTH-1:0]          power_in,
  input  logic                            start_i,
  output logic                            dct_done_o,
  output logic                            dct_valid_o,
  output logic [CEPS_WIDTH-1:0]           ceps_out,
  output logic [$clog2(NUM_CEPS)-1:0]     ceps_ptr_o
);

  localparam int NW     = $clog2(NUM_FILTERS);
  localparam int KW     = $clog2(NUM_CEPS);
  localparam int ACC_W  = INPUT_WIDTH + 17 + NW;
  localparam int PROD_W = INPUT_WIDTH + 1 + COS_WIDTH;

  localparam logic signed [ACC_W-1:0] CEPS_MAX = ACC_W'((1 << (CEPS_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] CEPS_MIN = ~CEPS_MAX;

  dct_state_e state_q, state_d;

  logic [INPUT_WIDTH-1:0]     frame_q [NUM_FILTERS];
  logic [NW-1:0]              n_q;
  logic [KW-1:0]              k_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [COS_WIDTH-1:0] coef;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc_shr;
  logic [CEPS_WIDTH-1:0]      ceps_sat;
  logic                       wr_en;

  dct_cos_rom #(
    .NUM_CEPS    (NUM_CEPS),
    .NUM_FILTERS (NUM_FILTERS)
  ) u_cos_rom (
    .k_idx (k_q),
    .n_idx (n_q),
    .coef  (coef)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_MAC;
      ST_MAC:  if (n_q == NW'(NUM_FILTERS - 1)) state_d = ST_OUT;
      ST_OUT:  state_d = (k_q == KW'(NUM_CEPS - 1)) ? ST_DONE : ST_MAC;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The buffer only accepts data between frames so a running DCT sees a stable frame.
  assign wr_en = (state_q == ST_IDLE) && in_valid && (32'(frame_ptr_i) < NUM_FILTERS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FILTERS; i++) frame_q[i] <= '0;
    end else if (wr_en) begin
      frame_q[frame_ptr_i] <= power_in;
    end
  end

  always_comb begin
    prod     = PROD_W'($signed({1'b0, frame_q[n_q]})) * PROD_W'(coef);
    acc_shr  = acc_q >>> Q_FRAC;
    ceps_sat = acc_shr[CEPS_WIDTH-1:0];
    if (acc_shr > CEPS_MAX) begin
      ceps_sat = {1'b0, {(CEPS_WIDTH - 1){1'b1}}};
    end else if (acc_shr < CEPS_MIN) begin
      ceps_sat = {1'b1, {(CEPS_WIDTH - 1){1'b0}}};
    end
  end

  // k_q carries k-1, which is both the ROM row and the output index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      dct_valid_o <= 1'b0;
      dct_done_o  <= 1'b0;
      ceps_out    <= '0;
      ceps_ptr_o  <= '0;
    end else begin
      dct_valid_o <= 1'b0;
      dct_done_o  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            n_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          n_q   <= n_q + 1'b1;
        end
        ST_OUT: begin
          dct_valid_o <= 1'b1;
          ceps_out    <= ceps_sat;
          ceps_ptr_o  <= k_q;
          k_q         <= k_q + 1'b1;
          n_q         <= '0;
          acc_q       <= '0;
        end
        ST_DONE: begin
          dct_done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_dct.sv
// tb/tb_mfcc_dct.sv - directed self-checking bench for mfcc_dct
module tb_mfcc_dct;

  localparam int N = 40;
  localparam int K = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  frame_ptr_i;
  logic [7:0]  power_in;
  logic        start_i;
  logic        dct_done_o;
  logic        dct_valid_o;
  logic [15:0] ceps_out;
  logic [3:0]  ceps_ptr_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_x [N];
  int cos_tab [K+1][N];
  longint exp_c [K];
  longint obs_c [K];

  mfcc_dct dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .frame_ptr_i (frame_ptr_i),
    .power_in    (power_in),
    .start_i     (start_i),
    .dct_done_o  (dct_done_o),
    .dct_valid_o (dct_valid_o),
    .ceps_out    (ceps_out),
    .ceps_ptr_o  (ceps_ptr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build_cos();
    real v;
    for (int k = 1; k <= K; k++) begin
      for (int n = 0; n < N; n++) begin
        v = 32768.0 * $cos(3.141592653589793 * k * (2 * n + 1) / (2.0 * N));
        cos_tab[k][n] = int'($floor(v + 0.5));
        if (cos_tab[k][n] > 32767) cos_tab[k][n] = 32767;
      end
    end
  endtask

  task automatic compute_exp();
    longint s;
    for (int k = 1; k <= K; k++) begin
      s = 0;
      for (int n = 0; n < N; n++) s += longint'(model_x[n]) * longint'(cos_tab[k][n]);
      s = s >>> 15;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      exp_c[k-1] = s;
    end
  endtask

  task automatic wr(input int ptr, input int val);
    @(negedge clk);
    in_valid    = 1'b1;
    frame_ptr_i = 6'(ptr);
    power_in    = 8'(val);
    @(negedge clk);
    in_valid = 1'b0;
    if (ptr < N) model_x[ptr] = val;
  endtask

  task automatic run_frame(input string tag, input bit busy_inj, input bit sim_wr, input int sim_val);
    int got_v;
    int got_d;
    @(negedge clk);
    start_i = 1'b1;
    if (sim_wr) begin
      in_valid       = 1'b1;
      frame_ptr_i    = 6'(N - 1);
      power_in       = 8'(sim_val);
      model_x[N - 1] = sim_val;
    end
    compute_exp();
    @(negedge clk);
    start_i  = 1'b0;
    in_valid = 1'b0;
    got_v = 0;
    got_d = 0;
    for (int cyc = 1; cyc <= 520; cyc++) begin
      @(negedge clk);
      if (dct_valid_o) begin
        if (got_v < K) begin
          obs_c[got_v] = longint'($signed(ceps_out));
          check({tag, "_time"}, cyc, (got_v + 1) * (N + 1));
          check({tag, "_ptr"}, ceps_ptr_o, got_v);
          check({tag, "_val"}, obs_c[got_v], exp_c[got_v]);
        end
        got_v++;
      end
      if (dct_done_o) begin
        if (got_d == 0) check({tag, "_done_time"}, cyc, K * (N + 1) + 1);
        got_d++;
      end
      if (busy_inj) begin
        start_i     = (cyc == 10);
        in_valid    = (cyc == 10);
        frame_ptr_i = 6'd0;
        power_in    = 8'd255;
      end
    end
    start_i  = 1'b0;
    in_valid = 1'b0;
    check({tag, "_nvalid"}, got_v, K);
    check({tag, "_ndone"}, got_d, 1);
  endtask

  initial begin
    int cnt;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    frame_ptr_i = '0;
    power_in    = '0;
    start_i     = 1'b0;
    for (int n = 0; n < N; n++) model_x[n] = 0;
    build_cos();
    repeat (3) @(negedge clk);
    check("rst_valid", dct_valid_o, 0);
    check("rst_done", dct_done_o, 0);
    check("rst_ceps", ceps_out, 0);
    check("rst_ptr", ceps_ptr_o, 0);
    rst_n = 1'b1;

    // Impulse at n=0: c[1] = floor(255*32743/32768) = 254
    wr(0, 255);
    for (int n = 1; n < N; n++) wr(n, 0);
    run_frame("imp", 1'b0, 1'b0, 0);
    check("imp_c1_literal", obs_c[0], 254);

    // Flat frame: ideal DCT is zero apart from Q1.15 rounding residue
    for (int n = 0; n < N; n++) wr(n, 100);
    run_frame("const", 1'b0, 1'b0, 0);
    for (int k = 0; k < K; k++) check("const_range", (obs_c[k] >= -2 && obs_c[k] <= 1), 1);

    for (int n = 0; n < N; n++) wr(n, int'($urandom_range(0, 255)));
    run_frame("rand1", 1'b0, 1'b0, 0);

    run_frame("busy", 1'b1, 1'b0, 0);

    // Partial update with dropped out-of-range pointers
    wr(5, 77);
    wr(40, 255);
    wr(63, 255);
    run_frame("part", 1'b0, 1'b0, 0);

    run_frame("simwr", 1'b1 == 1'b0, 1'b1, 200);

    // Reset mid-MAC: outputs clear at once, buffer clears, no done follows
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", dct_valid_o, 0);
    check("midrst_done", dct_done_o, 0);
    check("midrst_ceps", ceps_out, 0);
    check("midrst_ptr", ceps_ptr_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < N; n++) model_x[n] = 0;
    cnt = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (dct_valid_o || dct_done_o) cnt++;
    end
    check("midrst_quiet", cnt, 0);

    for (int n = 0; n < N; n += 2) wr(n, int'($urandom_range(0, 255)));
    run_frame("post_rst", 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
